arm_fetch: RTL and testbench

Instruction fetch stage that feeds `arm_core`. It generates word addresses, runs a request/acknowledge handshake with instruction memory, and buffers returned words in a small in-order prefetch FIFO. It presents one instruction at a time, together with its address, through a valid/ready interface. A redirect from the core (branch or PC write) flushes the buffer and restarts fetch at a new address.

---
 rtl/arm_fetch.sv | 108 ++++++++++
 tb/tb_arm_fetch.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_fetch.sv
// Instruction fetch stage for arm_core: single-outstanding memory requests
// feeding an in-order {addr, data} prefetch FIFO, with redirect/flush support.
module arm_fetch #(
    parameter logic [29:0] RESET_VECTOR = 30'h0,
    parameter int          DEPTH        = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic        redirect,
    input  logic [29:0] redirect_addr,
    input  logic        inst_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [29:0] inst_addr,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t         state;
    logic [29:0]    fetch_pc;
    logic [29:0]    req_addr;
    logic           busy;
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [CW-1:0]  count;
    logic [29:0]    fifo_addr [DEPTH];
    logic [31:0]    fifo_data [DEPTH];

    logic space;
    logic ack;
    logic pop;
    logic push;

    // Handshakes: a memory request completes on imem_req && imem_ack and is held
    // stable until then; an instruction transfers on inst_valid && inst_ready.
    assign space      = (count < FULL);
    assign imem_req   = !rst && (busy || (state == RUN && !halt && space));
    assign imem_addr  = busy ? req_addr : fetch_pc;
    assign ack        = imem_req && imem_ack;
    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready;
    assign push       = ack && (state == RUN) && !redirect;
    assign inst       = fifo_data[head];
    assign inst_addr  = fifo_addr[head];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            fetch_pc <= RESET_VECTOR;
            req_addr <= '0;
            busy     <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr[i] <= '0;
                fifo_data[i] <= '0;
            end
        end else begin
            busy <= imem_req && !imem_ack;
            if (imem_req && !busy) begin
                req_addr <= fetch_pc;
            end

            if (redirect) begin
                // A request that is still open must finish before the new stream starts.
                fetch_pc <= redirect_addr;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                state    <= (imem_req && !imem_ack) ? DRAIN : RUN;
            end else begin
                if (ack) begin
                    if (state == RUN) begin
                        fetch_pc <= fetch_pc + 30'd1;
                    end
                    state <= RUN;
                end
                if (push) begin
                    fifo_addr[tail] <= imem_addr;
                    fifo_data[tail] <= imem_data;
                    tail            <= tail + 1'b1;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_arm_fetch.sv
// Bench for arm_fetch: per-cycle vector table for streaming/backpressure, then
// hand sequences for redirect, wrap, halt and reset-in-drain.
module tb_arm_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        halt = 1'b0;
    logic        redirect = 1'b0;
    logic [29:0] redirect_addr = '0;
    logic        inst_ready = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [29:0] inst_addr;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          ack_delay = 0;
    int          wait_cnt;
    logic [29:0] exp_q[$];
    logic [29:0] exp_e;
    logic        prev_pend = 1'b0;
    logic [29:0] prev_addr = '0;

    typedef struct {
        bit          rst_before;
        logic        halt;
        logic        ready;
        logic        exp_req;
        logic [29:0] exp_addr;
        logic        exp_valid;
        logic [29:0] exp_iaddr;
    } vec_t;

    vec_t vecs[$];

    arm_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .halt          (halt),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .inst_ready    (inst_ready),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_addr     (inst_addr),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Memory model: acks after ack_delay wait cycles, data mirrors the address.
    assign imem_ack  = imem_req && (wait_cnt >= ack_delay);
    assign imem_data = {2'b00, imem_addr};

    always @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= 0;
        else if (imem_req && !imem_ack)
            wait_cnt <= wait_cnt + 1;
        else
            wait_cnt <= 0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard and request-stability monitor, sampled 1ns before the rising edge.
    always begin
        @(negedge clk);
        #4;
        if (rst) begin
            prev_pend = 1'b0;
        end else begin
            if (prev_pend) begin
                check("req_held", imem_req, 1);
                check("req_addr_held", imem_addr, prev_addr);
            end
            prev_pend = imem_req && !imem_ack;
            prev_addr = imem_addr;
            if (inst_valid && inst_ready && exp_q.size() > 0) begin
                exp_e = exp_q.pop_front();
                check("deliver_addr", inst_addr, exp_e);
                check("deliver_data", inst, {2'b00, exp_e});
            end
        end
    end

    // Driver tasks
    task automatic do_reset();
        rst = 1'b1;
        halt = 1'b0;
        redirect = 1'b0;
        redirect_addr = '0;
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic wait_req_start(input logic [29:0] a, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            #4;
            if (imem_req && imem_addr == a && wait_cnt == 0) found = 1'b1;
        end
        check(name, found, 1);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        check(name, exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
    endtask

    function automatic vec_t mk(bit rb, logic h, logic r, logic er, logic [29:0] ea,
                                logic ev, logic [29:0] ei);
        vec_t v;
        v.rst_before = rb;
        v.halt = h;
        v.ready = r;
        v.exp_req = er;
        v.exp_addr = ea;
        v.exp_valid = ev;
        v.exp_iaddr = ei;
        return v;
    endfunction

    initial begin
        // Zero-wait streaming: request c in cycle c, instruction c-1 visible.
        vecs.push_back(mk(1, 0, 1, 1, 30'd0, 0, 30'd0));
        vecs.push_back(mk(0, 0, 1, 1, 30'd1, 1, 30'd0));
        vecs.push_back(mk(0, 0, 1, 1, 30'd2, 1, 30'd1));
        vecs.push_back(mk(0, 0, 1, 1, 30'd3, 1, 30'd2));
        vecs.push_back(mk(0, 0, 1, 1, 30'd4, 1, 30'd3));
        // Backpressure: two acks fill the FIFO, then resume after a pop.
        vecs.push_back(mk(1, 0, 0, 1, 30'd0, 0, 30'd0));
        vecs.push_back(mk(0, 0, 0, 1, 30'd1, 1, 30'd0));
        vecs.push_back(mk(0, 0, 0, 0, 30'd2, 1, 30'd0));
        vecs.push_back(mk(0, 0, 0, 0, 30'd2, 1, 30'd0));
        vecs.push_back(mk(0, 0, 1, 0, 30'd2, 1, 30'd0));
        vecs.push_back(mk(0, 0, 1, 1, 30'd2, 1, 30'd1));
        vecs.push_back(mk(0, 0, 1, 1, 30'd3, 1, 30'd2));
        vecs.push_back(mk(0, 0, 1, 1, 30'd4, 1, 30'd3));

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_imem_req", imem_req, 0);
        check("rst_imem_addr", imem_addr, 30'h0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_addr", inst_addr, 30'h0);

        ack_delay = 0;
        foreach (vecs[i]) begin
            if (vecs[i].rst_before) do_reset();
            halt = vecs[i].halt;
            inst_ready = vecs[i].ready;
            #4;
            check($sformatf("vec%0d_imem_req", i), imem_req, vecs[i].exp_req);
            check($sformatf("vec%0d_imem_addr", i), imem_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_inst_valid", i), inst_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_inst_addr", i), inst_addr, vecs[i].exp_iaddr);
            check($sformatf("vec%0d_inst", i), inst, {2'b00, vecs[i].exp_iaddr});
            @(negedge clk);
        end

        // Redirect during a wait state
        ack_delay = 3;
        inst_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) exp_q.push_back(30'(i));
        exp_q.push_back(30'h100);
        exp_q.push_back(30'h101);
        wait_req_start(30'd5, "t3_req5_start");
        @(negedge clk);
        redirect = 1'b1;
        redirect_addr = 30'h100;
        #4;
        check("t3_hold1_addr", imem_addr, 30'd5);
        check("t3_hold1_req", imem_req, 1);
        @(negedge clk);
        redirect = 1'b0;
        #4;
        check("t3_hold2_addr", imem_addr, 30'd5);
        check("t3_flush_valid", inst_valid, 0);
        @(negedge clk);
        #4;
        check("t3_hold3_addr", imem_addr, 30'd5);
        @(negedge clk);
        #4;
        check("t3_new_req", imem_req, 1);
        check("t3_new_addr", imem_addr, 30'h100);
        wait_drain("t3_drain");

        // Redirect coincident with ack, and address wrap
        ack_delay = 1;
        do_reset();
        exp_q.push_back(30'd0);
        exp_q.push_back(30'd1);
        exp_q.push_back(30'd2);
        exp_q.push_back(30'h3FFFFFFF);
        exp_q.push_back(30'd0);
        wait_req_start(30'd3, "t4_req3_start");
        @(negedge clk);
        redirect = 1'b1;
        redirect_addr = 30'h3FFFFFFF;
        #4;
        check("t4_ack_addr", imem_addr, 30'd3);
        @(negedge clk);
        redirect = 1'b0;
        #4;
        check("t4_flush_valid", inst_valid, 0);
        check("t4_new_req", imem_req, 1);
        check("t4_new_addr", imem_addr, 30'h3FFFFFFF);
        wait_drain("t4_drain");

        // Halt with a request in flight
        ack_delay = 2;
        do_reset();
        for (int i = 0; i < 8; i++) exp_q.push_back(30'(i));
        wait_req_start(30'd7, "t5_req7_start");
        @(negedge clk);
        halt = 1'b1;
        #4;
        check("t5_inflight1_req", imem_req, 1);
        check("t5_inflight1_addr", imem_addr, 30'd7);
        @(negedge clk);
        #4;
        check("t5_inflight2_req", imem_req, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #4;
            check($sformatf("t5_halted%0d_req", i), imem_req, 0);
        end
        @(negedge clk);
        halt = 1'b0;
        #4;
        check("t5_resume_req", imem_req, 1);
        check("t5_resume_addr", imem_addr, 30'd8);
        wait_drain("t5_drain");

        // Reset asserted mid-cycle while draining
        ack_delay = 3;
        do_reset();
        wait_req_start(30'd2, "t6_req2_start");
        @(negedge clk);
        redirect = 1'b1;
        redirect_addr = 30'h50;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("t6_drain_req", imem_req, 1);
        check("t6_drain_addr", imem_addr, 30'd2);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_req", imem_req, 0);
        check("t6_rst_valid", inst_valid, 0);
        check("t6_rst_imem_addr", imem_addr, 30'h0);
        check("t6_rst_inst", inst, 32'h0);
        check("t6_rst_inst_addr", inst_addr, 30'h0);
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        exp_q.push_back(30'd0);
        exp_q.push_back(30'd1);
        exp_q.push_back(30'd2);
        rst = 1'b0;
        #4;
        check("t6_restart_req", imem_req, 1);
        check("t6_restart_addr", imem_addr, 30'h0);
        check("t6_restart_valid", inst_valid, 0);
        wait_drain("t6_drain");

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched",
                 n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
